// File: rtl/axi_mmio_router_pkg.sv
// Shared AXI field widths, FSM state types and default address windows for the router.
package axi_mmio_router_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;
    localparam int STRB_W = 8;

    localparam logic [ADDR_W-1:0] DEF_MEM_BASE  = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] DEF_MEM_SIZE  = 32'h0800_0000;
    localparam logic [ADDR_W-1:0] DEF_MMIO_BASE = 32'ha000_0000;
    localparam logic [ADDR_W-1:0] DEF_MMIO_SIZE = 32'h0100_0000;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MEM,
        R_MMIO,
        R_ERR
    } r_state_e;

    // W_ERR sinks the data beats; W_ERR_B holds the error write response.
    typedef enum logic [2:0] {
        W_IDLE,
        W_MEM,
        W_MMIO,
        W_ERR,
        W_ERR_B
    } w_state_e;

endpackage

// File: rtl/axi_addr_decode.sv
// Window compare for one address channel. Offsets wrap in 32-bit unsigned
// arithmetic, so an address below a base never looks like a hit.
module axi_addr_decode
    import axi_mmio_router_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE  = DEF_MEM_BASE,
    parameter logic [ADDR_W-1:0] MEM_SIZE  = DEF_MEM_SIZE,
    parameter logic [ADDR_W-1:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter logic [ADDR_W-1:0] MMIO_SIZE = DEF_MMIO_SIZE
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [1:0]        hit      // {hit_mem, hit_mmio}
);

    logic [ADDR_W-1:0] mem_off;
    logic [ADDR_W-1:0] mmio_off;

    // Raw window hits; the caller resolves overlap in favour of mem.
    always_comb begin
        mem_off  = addr - MEM_BASE;
        mmio_off = addr - MMIO_BASE;
        hit      = {(mem_off < MEM_SIZE), (mmio_off < MMIO_SIZE)};
    end

endmodule

// File: rtl/axi_mmio_router.sv
// Routes AXI read and write bursts from the arbiter to main memory or the MMIO bus.
// Each channel decodes on the start address, holds the route until the burst
// completes and answers unmapped addresses with a locally generated error burst.
module axi_mmio_router
    import axi_mmio_router_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE  = DEF_MEM_BASE,
    parameter logic [ADDR_W-1:0] MEM_SIZE  = DEF_MEM_SIZE,
    parameter logic [ADDR_W-1:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter logic [ADDR_W-1:0] MMIO_SIZE = DEF_MMIO_SIZE
) (
    input  logic              clock,
    input  logic              reset,
    // upstream master
    input  logic [ADDR_W-1:0] io_m_araddr,
    input  logic [LEN_W-1:0]  io_m_arlen,
    input  logic              io_m_arvalid,
    input  logic              io_m_rready,
    output logic [DATA_W-1:0] io_m_rdata,
    output logic              io_m_rlast,
    output logic              io_m_rvalid,
    input  logic [ADDR_W-1:0] io_m_awaddr,
    input  logic [LEN_W-1:0]  io_m_awlen,
    input  logic              io_m_awvalid,
    input  logic [DATA_W-1:0] io_m_wdata,
    input  logic [STRB_W-1:0] io_m_wstrb,
    input  logic              io_m_wvalid,
    input  logic              io_m_bready,
    output logic              io_m_wready,
    output logic              io_m_bvalid,
    // main memory slave
    output logic [ADDR_W-1:0] io_mem_araddr,
    output logic [LEN_W-1:0]  io_mem_arlen,
    output logic              io_mem_arvalid,
    output logic              io_mem_rready,
    input  logic [DATA_W-1:0] io_mem_rdata,
    input  logic              io_mem_rlast,
    input  logic              io_mem_rvalid,
    output logic [ADDR_W-1:0] io_mem_awaddr,
    output logic [LEN_W-1:0]  io_mem_awlen,
    output logic              io_mem_awvalid,
    output logic [DATA_W-1:0] io_mem_wdata,
    output logic [STRB_W-1:0] io_mem_wstrb,
    output logic              io_mem_wvalid,
    output logic              io_mem_bready,
    input  logic              io_mem_wready,
    input  logic              io_mem_bvalid,
    // MMIO device bus slave
    output logic [ADDR_W-1:0] io_mmio_araddr,
    output logic [LEN_W-1:0]  io_mmio_arlen,
    output logic              io_mmio_arvalid,
    output logic              io_mmio_rready,
    input  logic [DATA_W-1:0] io_mmio_rdata,
    input  logic              io_mmio_rlast,
    input  logic              io_mmio_rvalid,
    output logic [ADDR_W-1:0] io_mmio_awaddr,
    output logic [LEN_W-1:0]  io_mmio_awlen,
    output logic              io_mmio_awvalid,
    output logic [DATA_W-1:0] io_mmio_wdata,
    output logic [STRB_W-1:0] io_mmio_wstrb,
    output logic              io_mmio_wvalid,
    output logic              io_mmio_bready,
    input  logic              io_mmio_wready,
    input  logic              io_mmio_bvalid,
    // unmapped-burst pulses
    output logic              io_err_rd,
    output logic              io_err_wr
);

    r_state_e          r_state, r_next;
    logic [LEN_W-1:0]  r_cnt, r_cnt_next;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [LEN_W-1:0]  ar_len_q;
    logic [1:0]        rd_hit;

    w_state_e          w_state, w_next;
    logic [LEN_W-1:0]  w_cnt, w_cnt_next;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [LEN_W-1:0]  aw_len_q;
    logic [1:0]        wr_hit;

    axi_addr_decode #(
        .MEM_BASE (MEM_BASE),  .MEM_SIZE (MEM_SIZE),
        .MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE)
    ) u_rd_decode (
        .addr(io_m_araddr),
        .hit (rd_hit)
    );

    axi_addr_decode #(
        .MEM_BASE (MEM_BASE),  .MEM_SIZE (MEM_SIZE),
        .MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE)
    ) u_wr_decode (
        .addr(io_m_awaddr),
        .hit (wr_hit)
    );

    // Read state register; the request is captured together with the routing decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
        end else begin
            r_state <= r_next;
            r_cnt   <= r_cnt_next;
            if (r_state == R_IDLE && io_m_arvalid) begin
                ar_addr_q <= io_m_araddr;
                ar_len_q  <= io_m_arlen;
            end
        end
    end

    // Read next-state and channel muxing; unselected slave inputs stay at 0.
    always_comb begin
        r_next          = r_state;
        r_cnt_next      = r_cnt;
        io_err_rd       = 1'b0;
        io_m_rdata      = '0;
        io_m_rlast      = 1'b0;
        io_m_rvalid     = 1'b0;
        io_mem_araddr   = '0;
        io_mem_arlen    = '0;
        io_mem_arvalid  = 1'b0;
        io_mem_rready   = 1'b0;
        io_mmio_araddr  = '0;
        io_mmio_arlen   = '0;
        io_mmio_arvalid = 1'b0;
        io_mmio_rready  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (io_m_arvalid) begin
                    if (rd_hit[1]) begin
                        r_next = R_MEM;
                    end else if (rd_hit[0]) begin
                        r_next = R_MMIO;
                    end else begin
                        r_next     = R_ERR;
                        r_cnt_next = io_m_arlen;
                        io_err_rd  = !reset;
                    end
                end
            end
            R_MEM: begin
                io_mem_araddr  = ar_addr_q;
                io_mem_arlen   = ar_len_q;
                io_mem_arvalid = io_m_arvalid;
                io_mem_rready  = io_m_rready;
                io_m_rdata     = io_mem_rdata;
                io_m_rlast     = io_mem_rlast;
                io_m_rvalid    = io_mem_rvalid;
                if (io_mem_rvalid && io_m_rready && io_mem_rlast)
                    r_next = R_IDLE;
            end
            R_MMIO: begin
                io_mmio_araddr  = ar_addr_q;
                io_mmio_arlen   = ar_len_q;
                io_mmio_arvalid = io_m_arvalid;
                io_mmio_rready  = io_m_rready;
                io_m_rdata      = io_mmio_rdata;
                io_m_rlast      = io_mmio_rlast;
                io_m_rvalid     = io_mmio_rvalid;
                if (io_mmio_rvalid && io_m_rready && io_mmio_rlast)
                    r_next = R_IDLE;
            end
            R_ERR: begin
                // Counter holds beats remaining after the current one, so arlen=255 gives 256 beats.
                io_m_rvalid = 1'b1;
                io_m_rlast  = (r_cnt == '0);
                if (io_m_rready) begin
                    if (r_cnt == '0) r_next = R_IDLE;
                    else             r_cnt_next = r_cnt - 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write state register; the request is captured together with the routing decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
        end else begin
            w_state <= w_next;
            w_cnt   <= w_cnt_next;
            if (w_state == W_IDLE && io_m_awvalid) begin
                aw_addr_q <= io_m_awaddr;
                aw_len_q  <= io_m_awlen;
            end
        end
    end

    // Write next-state and channel muxing; error bursts are sunk locally then answered.
    always_comb begin
        w_next          = w_state;
        w_cnt_next      = w_cnt;
        io_err_wr       = 1'b0;
        io_m_wready     = 1'b0;
        io_m_bvalid     = 1'b0;
        io_mem_awaddr   = '0;
        io_mem_awlen    = '0;
        io_mem_awvalid  = 1'b0;
        io_mem_wdata    = '0;
        io_mem_wstrb    = '0;
        io_mem_wvalid   = 1'b0;
        io_mem_bready   = 1'b0;
        io_mmio_awaddr  = '0;
        io_mmio_awlen   = '0;
        io_mmio_awvalid = 1'b0;
        io_mmio_wdata   = '0;
        io_mmio_wstrb   = '0;
        io_mmio_wvalid  = 1'b0;
        io_mmio_bready  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (io_m_awvalid) begin
                    if (wr_hit[1]) begin
                        w_next = W_MEM;
                    end else if (wr_hit[0]) begin
                        w_next = W_MMIO;
                    end else begin
                        w_next     = W_ERR;
                        w_cnt_next = io_m_awlen;
                        io_err_wr  = !reset;
                    end
                end
            end
            W_MEM: begin
                io_mem_awaddr  = aw_addr_q;
                io_mem_awlen   = aw_len_q;
                io_mem_awvalid = io_m_awvalid;
                io_mem_wdata   = io_m_wdata;
                io_mem_wstrb   = io_m_wstrb;
                io_mem_wvalid  = io_m_wvalid;
                io_mem_bready  = io_m_bready;
                io_m_wready    = io_mem_wready;
                io_m_bvalid    = io_mem_bvalid;
                if (io_mem_bvalid && io_m_bready) w_next = W_IDLE;
            end
            W_MMIO: begin
                io_mmio_awaddr  = aw_addr_q;
                io_mmio_awlen   = aw_len_q;
                io_mmio_awvalid = io_m_awvalid;
                io_mmio_wdata   = io_m_wdata;
                io_mmio_wstrb   = io_m_wstrb;
                io_mmio_wvalid  = io_m_wvalid;
                io_mmio_bready  = io_m_bready;
                io_m_wready     = io_mmio_wready;
                io_m_bvalid     = io_mmio_bvalid;
                if (io_mmio_bvalid && io_m_bready) w_next = W_IDLE;
            end
            W_ERR: begin
                io_m_wready = 1'b1;
                if (io_m_wvalid) begin
                    if (w_cnt == '0) w_next = W_ERR_B;
                    else             w_cnt_next = w_cnt - 1'b1;
                end
            end
            W_ERR_B: begin
                io_m_bvalid = 1'b1;
                if (io_m_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // The master must keep its request valid until the burst it opened has completed.
    a_arvalid_held: assert property (@(posedge clock) disable iff (reset)
        (r_state != R_IDLE) |-> io_m_arvalid);
    a_awvalid_held: assert property (@(posedge clock) disable iff (reset)
        (w_state != W_IDLE) |-> io_m_awvalid);

endmodule

// File: tb/tb_axi_mmio_router.sv
// Directed bench for axi_mmio_router: the bench plays both slaves by hand and
// checks routing, error bursts, boundaries and mid-burst reset.
module tb_axi_mmio_router;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] io_m_araddr, io_m_awaddr;
    logic [7:0]  io_m_arlen, io_m_awlen, io_m_wstrb;
    logic        io_m_arvalid, io_m_rready, io_m_awvalid, io_m_wvalid, io_m_bready;
    logic [63:0] io_m_wdata, io_m_rdata;
    logic        io_m_rlast, io_m_rvalid, io_m_wready, io_m_bvalid;
    logic [31:0] io_mem_araddr, io_mem_awaddr, io_mmio_araddr, io_mmio_awaddr;
    logic [7:0]  io_mem_arlen, io_mem_awlen, io_mem_wstrb, io_mmio_arlen, io_mmio_awlen, io_mmio_wstrb;
    logic        io_mem_arvalid, io_mem_rready, io_mem_awvalid, io_mem_wvalid, io_mem_bready;
    logic        io_mmio_arvalid, io_mmio_rready, io_mmio_awvalid, io_mmio_wvalid, io_mmio_bready;
    logic [63:0] io_mem_wdata, io_mmio_wdata, io_mem_rdata, io_mmio_rdata;
    logic        io_mem_rlast, io_mem_rvalid, io_mem_wready, io_mem_bvalid;
    logic        io_mmio_rlast, io_mmio_rvalid, io_mmio_wready, io_mmio_bvalid;
    logic        io_err_rd, io_err_wr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axi_mmio_router dut (
        .clock(clock), .reset(reset),
        .io_m_araddr(io_m_araddr), .io_m_arlen(io_m_arlen), .io_m_arvalid(io_m_arvalid),
        .io_m_rready(io_m_rready), .io_m_rdata(io_m_rdata), .io_m_rlast(io_m_rlast),
        .io_m_rvalid(io_m_rvalid), .io_m_awaddr(io_m_awaddr), .io_m_awlen(io_m_awlen),
        .io_m_awvalid(io_m_awvalid), .io_m_wdata(io_m_wdata), .io_m_wstrb(io_m_wstrb),
        .io_m_wvalid(io_m_wvalid), .io_m_bready(io_m_bready), .io_m_wready(io_m_wready),
        .io_m_bvalid(io_m_bvalid),
        .io_mem_araddr(io_mem_araddr), .io_mem_arlen(io_mem_arlen), .io_mem_arvalid(io_mem_arvalid),
        .io_mem_rready(io_mem_rready), .io_mem_rdata(io_mem_rdata), .io_mem_rlast(io_mem_rlast),
        .io_mem_rvalid(io_mem_rvalid), .io_mem_awaddr(io_mem_awaddr), .io_mem_awlen(io_mem_awlen),
        .io_mem_awvalid(io_mem_awvalid), .io_mem_wdata(io_mem_wdata), .io_mem_wstrb(io_mem_wstrb),
        .io_mem_wvalid(io_mem_wvalid), .io_mem_bready(io_mem_bready), .io_mem_wready(io_mem_wready),
        .io_mem_bvalid(io_mem_bvalid),
        .io_mmio_araddr(io_mmio_araddr), .io_mmio_arlen(io_mmio_arlen), .io_mmio_arvalid(io_mmio_arvalid),
        .io_mmio_rready(io_mmio_rready), .io_mmio_rdata(io_mmio_rdata), .io_mmio_rlast(io_mmio_rlast),
        .io_mmio_rvalid(io_mmio_rvalid), .io_mmio_awaddr(io_mmio_awaddr), .io_mmio_awlen(io_mmio_awlen),
        .io_mmio_awvalid(io_mmio_awvalid), .io_mmio_wdata(io_mmio_wdata), .io_mmio_wstrb(io_mmio_wstrb),
        .io_mmio_wvalid(io_mmio_wvalid), .io_mmio_bready(io_mmio_bready), .io_mmio_wready(io_mmio_wready),
        .io_mmio_bvalid(io_mmio_bvalid),
        .io_err_rd(io_err_rd), .io_err_wr(io_err_wr)
    );

    task automatic clear_slaves();
        io_mem_rdata = '0;  io_mem_rlast = 0;  io_mem_rvalid = 0;  io_mem_wready = 0;  io_mem_bvalid = 0;
        io_mmio_rdata = '0; io_mmio_rlast = 0; io_mmio_rvalid = 0; io_mmio_wready = 0; io_mmio_bvalid = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        io_m_araddr = '0; io_m_arlen = '0; io_m_arvalid = 0; io_m_rready = 0;
        io_m_awaddr = '0; io_m_awlen = '0; io_m_awvalid = 0; io_m_wdata = '0;
        io_m_wstrb = '0; io_m_wvalid = 0; io_m_bready = 0;
        clear_slaves();
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        checks++;
        if ({io_m_rvalid, io_m_rlast, io_m_rdata, io_m_wready, io_m_bvalid, io_err_rd, io_err_wr} !== '0) begin
            errors++; $display("FAIL reset_upstream: got %h want 0",
                {io_m_rvalid, io_m_rlast, io_m_rdata, io_m_wready, io_m_bvalid, io_err_rd, io_err_wr});
        end
        checks++;
        if ({io_mem_arvalid, io_mem_awvalid, io_mem_wvalid, io_mmio_arvalid, io_mmio_awvalid, io_mmio_wvalid} !== '0) begin
            errors++; $display("FAIL reset_slaves: got %b want 0",
                {io_mem_arvalid, io_mem_awvalid, io_mem_wvalid, io_mmio_arvalid, io_mmio_awvalid, io_mmio_wvalid});
        end
        reset = 0;
    endtask

    task automatic test_mem_read();
        logic [65:0] exp;
        @(negedge clock);
        io_m_araddr = 32'h8000_0000; io_m_arlen = 8'd3; io_m_arvalid = 1; io_m_rready = 1;
        #1;
        checks++;
        if ({io_err_rd, io_m_rvalid, io_mem_arvalid} !== 3'b000) begin
            errors++; $display("FAIL memrd_idle: got %b want 000", {io_err_rd, io_m_rvalid, io_mem_arvalid});
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            io_mem_rvalid = 1; io_mem_rdata = 64'h1000 + 64'(b); io_mem_rlast = (b == 3);
            io_mmio_rvalid = 1; io_mmio_rdata = 64'hbad;
            #1;
            exp = {1'b1, (b == 3), 64'h1000 + 64'(b)};
            checks++;
            if ({io_m_rvalid, io_m_rlast, io_m_rdata} !== exp) begin
                errors++; $display("FAIL memrd_beat%0d: got %h want %h", b, {io_m_rvalid, io_m_rlast, io_m_rdata}, exp);
            end
            checks++;
            if ({io_mem_arvalid, io_mem_rready, io_mem_araddr, io_mem_arlen, io_mmio_arvalid, io_mmio_rready}
                    !== {2'b11, 32'h8000_0000, 8'd3, 2'b00}) begin
                errors++; $display("FAIL memrd_route%0d: got %h want %h", b,
                    {io_mem_arvalid, io_mem_rready, io_mem_araddr, io_mem_arlen, io_mmio_arvalid, io_mmio_rready},
                    {2'b11, 32'h8000_0000, 8'd3, 2'b00});
            end
        end
        @(negedge clock);
        io_m_arvalid = 0; io_m_rready = 0;
        #1;
        checks++;
        if ({io_m_rvalid, io_m_rdata, io_mem_araddr} !== '0) begin
            errors++; $display("FAIL memrd_done: got %h want 0", {io_m_rvalid, io_m_rdata, io_mem_araddr});
        end
        clear_slaves();
    endtask

    task automatic test_mmio_write();
        @(negedge clock);
        io_m_awaddr = 32'ha000_03f8; io_m_awlen = 8'd0; io_m_awvalid = 1;
        io_m_wdata = 64'hdead_beef_0123_4567; io_m_wstrb = 8'h0f; io_m_wvalid = 1; io_m_bready = 0;
        #1;
        checks++;
        if ({io_err_wr, io_m_wready, io_mmio_awvalid} !== 3'b000) begin
            errors++; $display("FAIL mmiowr_idle: got %b want 000", {io_err_wr, io_m_wready, io_mmio_awvalid});
        end
        @(negedge clock);
        io_mmio_wready = 1; io_mem_wready = 1;
        #1;
        checks++;
        if ({io_mmio_awvalid, io_mmio_awaddr, io_mmio_awlen, io_mmio_wvalid, io_mmio_wdata, io_mmio_wstrb, io_m_wready}
                !== {1'b1, 32'ha000_03f8, 8'd0, 1'b1, 64'hdead_beef_0123_4567, 8'h0f, 1'b1}) begin
            errors++; $display("FAIL mmiowr_fwd: got %h want %h",
                {io_mmio_awvalid, io_mmio_awaddr, io_mmio_awlen, io_mmio_wvalid, io_mmio_wdata, io_mmio_wstrb, io_m_wready},
                {1'b1, 32'ha000_03f8, 8'd0, 1'b1, 64'hdead_beef_0123_4567, 8'h0f, 1'b1});
        end
        checks++;
        if ({io_mem_awvalid, io_mem_wvalid, io_mem_wdata, io_mem_wstrb} !== '0) begin
            errors++; $display("FAIL mmiowr_memquiet: got %h want 0", {io_mem_awvalid, io_mem_wvalid, io_mem_wdata, io_mem_wstrb});
        end
        @(negedge clock);
        io_m_wvalid = 0; io_mmio_wready = 0; io_mmio_bvalid = 1; io_m_bready = 1;
        #1;
        checks++;
        if ({io_m_bvalid, io_mmio_bready} !== 2'b11) begin
            errors++; $display("FAIL mmiowr_resp: got %b want 11", {io_m_bvalid, io_mmio_bready});
        end
        @(negedge clock);
        io_m_awvalid = 0; io_m_bready = 0;
        #1;
        checks++;
        if ({io_m_bvalid, io_mmio_bready, io_mmio_awvalid} !== 3'b000) begin
            errors++; $display("FAIL mmiowr_idle_after: got %b want 000", {io_m_bvalid, io_mmio_bready, io_mmio_awvalid});
        end
        clear_slaves();
    endtask

    task automatic test_err_read();
        @(negedge clock);
        io_m_araddr = 32'h0000_1000; io_m_arlen = 8'd1; io_m_arvalid = 1; io_m_rready = 0;
        #1;
        checks++;
        if (io_err_rd !== 1'b1) begin errors++; $display("FAIL errrd_pulse: got %b want 1", io_err_rd); end
        @(negedge clock); #1;
        checks++;
        if ({io_err_rd, io_m_rvalid, io_m_rlast, io_m_rdata, io_mem_arvalid, io_mmio_arvalid} !== {2'b01, 1'b0, 64'h0, 2'b00}) begin
            errors++; $display("FAIL errrd_beat0: got %h want %h",
                {io_err_rd, io_m_rvalid, io_m_rlast, io_m_rdata, io_mem_arvalid, io_mmio_arvalid}, {2'b01, 1'b0, 64'h0, 2'b00});
        end
        @(negedge clock); io_m_rready = 1; #1;
        checks++;
        if ({io_m_rvalid, io_m_rlast} !== 2'b10) begin
            errors++; $display("FAIL errrd_stall: got %b want 10", {io_m_rvalid, io_m_rlast});
        end
        @(negedge clock); #1;
        checks++;
        if ({io_m_rvalid, io_m_rlast, io_m_rdata} !== {2'b11, 64'h0}) begin
            errors++; $display("FAIL errrd_last: got %h want %h", {io_m_rvalid, io_m_rlast, io_m_rdata}, {2'b11, 64'h0});
        end
        @(negedge clock); io_m_arvalid = 0; io_m_rready = 0; #1;
        checks++;
        if ({io_m_rvalid, io_m_rlast} !== 2'b00) begin
            errors++; $display("FAIL errrd_done: got %b want 00", {io_m_rvalid, io_m_rlast});
        end
    endtask

    task automatic test_err_write();
        @(negedge clock);
        io_m_awaddr = 32'h0000_0040; io_m_awlen = 8'd1; io_m_awvalid = 1; io_m_wvalid = 0; io_m_bready = 0;
        #1;
        checks++;
        if (io_err_wr !== 1'b1) begin errors++; $display("FAIL errwr_pulse: got %b want 1", io_err_wr); end
        for (int b = 0; b < 2; b++) begin
            @(negedge clock); io_m_wvalid = 1; io_m_wdata = 64'h77 + 64'(b); #1;
            checks++;
            if ({io_err_wr, io_m_wready, io_m_bvalid, io_mem_wvalid, io_mmio_wvalid} !== 5'b01000) begin
                errors++; $display("FAIL errwr_sink%0d: got %b want 01000", b,
                    {io_err_wr, io_m_wready, io_m_bvalid, io_mem_wvalid, io_mmio_wvalid});
            end
        end
        @(negedge clock); io_m_wvalid = 0; #1;
        checks++;
        if ({io_m_wready, io_m_bvalid} !== 2'b01) begin
            errors++; $display("FAIL errwr_resp: got %b want 01", {io_m_wready, io_m_bvalid});
        end
        @(negedge clock); #1;
        checks++;
        if (io_m_bvalid !== 1'b1) begin errors++; $display("FAIL errwr_hold: got %b want 1", io_m_bvalid); end
        @(negedge clock); io_m_bready = 1; #1;
        @(negedge clock); io_m_awvalid = 0; io_m_bready = 0; #1;
        checks++;
        if ({io_m_wready, io_m_bvalid} !== 2'b00) begin
            errors++; $display("FAIL errwr_done: got %b want 00", {io_m_wready, io_m_bvalid});
        end
    endtask

    task automatic test_concurrent();
        logic [65:0] exp;
        @(negedge clock);
        io_m_araddr = 32'h8000_0100; io_m_arlen = 8'd7; io_m_arvalid = 1; io_m_rready = 1;
        io_m_awaddr = 32'ha000_0010; io_m_awlen = 8'd1; io_m_awvalid = 1; io_m_wstrb = 8'hff;
        io_m_wvalid = 0; io_m_bready = 0;
        #1;
        checks++;
        if ({io_err_rd, io_err_wr} !== 2'b00) begin
            errors++; $display("FAIL conc_noerr: got %b want 00", {io_err_rd, io_err_wr});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            io_mem_rvalid = 1; io_mem_rdata = 64'h100 + 64'(i); io_mem_rlast = (i == 7);
            io_mmio_rvalid = 1; io_mmio_rdata = 64'hbad; io_mem_wready = 1; io_mem_bvalid = 1;
            if (i < 2) begin
                io_m_wvalid = 1; io_m_wdata = 64'h200 + 64'(i); io_mmio_wready = 1;
            end else if (i == 2) begin
                io_m_wvalid = 0; io_mmio_wready = 0; io_mmio_bvalid = 1; io_m_bready = 1;
            end else begin
                io_m_awvalid = 0; io_m_bready = 0; io_mmio_bvalid = 0;
            end
            #1;
            exp = {1'b1, (i == 7), 64'h100 + 64'(i)};
            checks++;
            if ({io_m_rvalid, io_m_rlast, io_m_rdata} !== exp) begin
                errors++; $display("FAIL conc_rd%0d: got %h want %h", i, {io_m_rvalid, io_m_rlast, io_m_rdata}, exp);
            end
            checks++;
            if ({io_mmio_arvalid, io_mmio_rready, io_mem_awvalid, io_mem_wvalid, io_mem_bready} !== 5'b0) begin
                errors++; $display("FAIL conc_xtalk%0d: got %b want 00000", i,
                    {io_mmio_arvalid, io_mmio_rready, io_mem_awvalid, io_mem_wvalid, io_mem_bready});
            end
            checks++;
            if (i < 2) begin
                if ({io_m_wready, io_m_bvalid, io_mmio_wvalid, io_mmio_wdata} !== {3'b101, 64'h200 + 64'(i)}) begin
                    errors++; $display("FAIL conc_wr%0d: got %h want %h", i,
                        {io_m_wready, io_m_bvalid, io_mmio_wvalid, io_mmio_wdata}, {3'b101, 64'h200 + 64'(i)});
                end
            end else if (i == 2) begin
                if ({io_m_wready, io_m_bvalid, io_mmio_bready} !== 3'b011) begin
                    errors++; $display("FAIL conc_wr%0d: got %b want 011", i, {io_m_wready, io_m_bvalid, io_mmio_bready});
                end
            end else begin
                if ({io_m_wready, io_m_bvalid, io_mmio_awvalid} !== 3'b000) begin
                    errors++; $display("FAIL conc_wr%0d: got %b want 000", i, {io_m_wready, io_m_bvalid, io_mmio_awvalid});
                end
            end
        end
        @(negedge clock);
        io_m_arvalid = 0; io_m_rready = 0;
        #1;
        checks++;
        if ({io_m_rvalid, io_mem_arvalid} !== 2'b00) begin
            errors++; $display("FAIL conc_done: got %b want 00", {io_m_rvalid, io_mem_arvalid});
        end
        clear_slaves();
    endtask

    task automatic test_boundaries();
        int beats;
        bit done;
        @(negedge clock);
        io_m_araddr = 32'h87ff_fff8; io_m_arlen = 8'd0; io_m_arvalid = 1; io_m_rready = 1;
        #1;
        checks++;
        if (io_err_rd !== 1'b0) begin errors++; $display("FAIL bnd_memtop_err: got %b want 0", io_err_rd); end
        @(negedge clock);
        io_mem_rvalid = 1; io_mem_rlast = 1; io_mem_rdata = 64'h55;
        #1;
        checks++;
        if ({io_mem_arvalid, io_mem_araddr, io_m_rvalid, io_m_rlast, io_m_rdata} !== {1'b1, 32'h87ff_fff8, 2'b11, 64'h55}) begin
            errors++; $display("FAIL bnd_memtop_route: got %h want %h",
                {io_mem_arvalid, io_mem_araddr, io_m_rvalid, io_m_rlast, io_m_rdata}, {1'b1, 32'h87ff_fff8, 2'b11, 64'h55});
        end
        @(negedge clock);
        io_m_arvalid = 0; clear_slaves();
        @(negedge clock);
        io_m_araddr = 32'h8800_0000; io_m_arlen = 8'd255; io_m_arvalid = 1;
        #1;
        checks++;
        if (io_err_rd !== 1'b1) begin errors++; $display("FAIL bnd_memend_err: got %b want 1", io_err_rd); end
        beats = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clock); #1;
            if (io_m_rvalid && io_m_rdata == 64'h0) beats++;
            if (io_m_rlast) done = 1;
        end
        checks++;
        if (!done || beats != 256) begin
            errors++; $display("FAIL bnd_256beats: got done=%0d beats=%0d want done=1 beats=256", done, beats);
        end
        @(negedge clock);
        io_m_arvalid = 0; io_m_rready = 0;
        #1;
        checks++;
        if (io_m_rvalid !== 1'b0) begin errors++; $display("FAIL bnd_256_done: got %b want 0", io_m_rvalid); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clock);
        io_m_araddr = 32'h8000_0000; io_m_arlen = 8'd3; io_m_arvalid = 1; io_m_rready = 1;
        @(negedge clock);
        io_mem_rvalid = 1; io_mem_rdata = 64'haaaa; io_mem_rlast = 0;
        #1;
        checks++;
        if ({io_m_rvalid, io_m_rdata} !== {1'b1, 64'haaaa}) begin
            errors++; $display("FAIL rstmid_beat1: got %h want %h", {io_m_rvalid, io_m_rdata}, {1'b1, 64'haaaa});
        end
        @(negedge clock);
        io_mem_rdata = 64'hbbbb; reset = 1; io_m_arvalid = 0; io_m_rready = 0;
        @(negedge clock); #1;
        checks++;
        if ({io_m_rvalid, io_m_rlast, io_m_rdata, io_mem_arvalid, io_mem_araddr, io_mem_rready, io_err_rd} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got %h want 0",
                {io_m_rvalid, io_m_rlast, io_m_rdata, io_mem_arvalid, io_mem_araddr, io_mem_rready, io_err_rd});
        end
        reset = 0; clear_slaves();
        io_m_araddr = 32'ha000_0000; io_m_arlen = 8'd0; io_m_arvalid = 1; io_m_rready = 1;
        @(negedge clock);
        io_mmio_rvalid = 1; io_mmio_rlast = 1; io_mmio_rdata = 64'hcccc;
        #1;
        checks++;
        if ({io_mmio_arvalid, io_mmio_araddr, io_m_rvalid, io_m_rlast, io_m_rdata, io_mem_arvalid}
                !== {1'b1, 32'ha000_0000, 2'b11, 64'hcccc, 1'b0}) begin
            errors++; $display("FAIL rstmid_fresh: got %h want %h",
                {io_mmio_arvalid, io_mmio_araddr, io_m_rvalid, io_m_rlast, io_m_rdata, io_mem_arvalid},
                {1'b1, 32'ha000_0000, 2'b11, 64'hcccc, 1'b0});
        end
        @(negedge clock);
        io_m_arvalid = 0; io_m_rready = 0; clear_slaves();
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_mmio_write();
        test_err_read();
        test_err_write();
        test_concurrent();
        test_boundaries();
        test_reset_mid_burst();
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
